// File: rtl/a1339_spi_responder.sv
`timescale 1ns/1ps
// A1339 angle-sensor SPI slave (mode 3) for HIL/bench use; the answer to a command is shifted out in the next frame.
// Latency: SYNC_STAGES+1 clock cycles from an SPI pin change to the internal edge strobe; the response is latched at ss_n rise.
// Backpressure: none; the SPI master owns timing, and sck_i must stay at or below clock/8.
module a1339_spi_responder #(
    parameter logic [15:0] ID_WORD     = 16'hA133,
    parameter int          SYNC_STAGES = 2          // must be >= 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sck_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    input  logic [11:0] angle_i,
    input  logic        angle_valid_i,
    input  logic        error_i,
    output logic [15:0] rx_word_o,
    output logic        frame_done_o,
    output logic        frame_error_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    localparam logic [6:0] ADDR_ID     = 7'h00;
    localparam logic [6:0] ADDR_OFS_LO = 7'h1E;
    localparam logic [6:0] ADDR_OFS_HI = 7'h1F;
    localparam logic [6:0] ADDR_ANGLE  = 7'h20;
    localparam logic [6:0] ADDR_TURNS  = 7'h2C;

    localparam logic [4:0] FRAME_BITS = 5'd16;

    // Synchroniser chains, MSB is the synchronised value
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   ss_prev;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic ss_fall;
    logic ss_rise;

    // FSM and shift state
    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_sr;
    logic [15:0] tx_sr;
    logic        miso_q;
    logic [15:0] pending;

    // Sensor model state
    logic [11:0] offset;
    logic        sticky_err;
    logic [11:0] turns;
    logic [11:0] prev_angle;
    logic        prev_vld;

    // Command decode and response formation
    logic        cmd_wr;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        frame_ok;
    logic [11:0] angle_adj;
    logic        angle_par;
    logic [15:0] read_resp;

    // Pins are asynchronous to clock. ss_n resets to "selected" so that a
    // reset released while ss_n is already low does not look like a new
    // frame start; the remainder of that frame is then ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '1;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b1;
            ss_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sck_prev  <= sck_s;
            ss_prev   <= ss_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign ss_fall  = ss_prev & ~ss_s;
    assign ss_rise  = ~ss_prev & ss_s;

    assign cmd_wr   = rx_sr[15];
    assign cmd_addr = rx_sr[14:8];
    assign cmd_data = rx_sr[7:0];
    assign frame_ok = (bit_cnt == FRAME_BITS);

    // Angle field is relative to the programmed zero offset, modulo one turn
    assign angle_adj = angle_i - offset;
    // Parity bit makes the total count of ones in the 16-bit word odd
    assign angle_par = ~(^{error_i, sticky_err, angle_adj});

    // Read response for the command just received, sampled at the latch cycle
    always_comb begin
        read_resp = 16'h0000;
        case (cmd_addr)
            ADDR_ID:     read_resp = ID_WORD;
            ADDR_OFS_LO: read_resp = {8'h00, offset[7:0]};
            ADDR_OFS_HI: read_resp = {12'h000, offset[11:8]};
            ADDR_ANGLE:  read_resp = {error_i, sticky_err, 1'b0, angle_par, angle_adj};
            ADDR_TURNS:  read_resp = {4'h0, turns};
            default:     read_resp = 16'h0000;
        endcase
    end

    // Frame FSM: load pending response, shift both directions, then execute
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            miso_q        <= 1'b1;
            pending       <= 16'h0000;
            rx_word_o     <= 16'h0000;
            frame_done_o  <= 1'b0;
            frame_error_o <= 1'b0;
            offset        <= '0;
            sticky_err    <= 1'b0;
        end else begin
            frame_done_o  <= 1'b0;
            frame_error_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        tx_sr   <= pending;
                        miso_q  <= pending[15];
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state <= ST_END;
                        if (frame_ok) begin
                            rx_word_o    <= rx_sr;
                            frame_done_o <= 1'b1;
                            if (cmd_wr) begin
                                if (cmd_addr == ADDR_OFS_LO) begin
                                    offset[7:0] <= cmd_data;
                                end
                                if (cmd_addr == ADDR_OFS_HI) begin
                                    offset[11:8] <= cmd_data[3:0];
                                end
                                pending <= 16'h0000;
                            end else begin
                                pending <= read_resp;
                                if (cmd_addr == ADDR_ANGLE) begin
                                    sticky_err <= 1'b0;
                                end
                            end
                        end else begin
                            frame_error_o <= 1'b1;
                            sticky_err    <= 1'b1;
                        end
                    end else begin
                        // Master samples on rising sck; capture MOSI there
                        if (sck_rise && !frame_ok) begin
                            rx_sr   <= {rx_sr[14:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        // The leading falling edge only opens bit 15; later
                        // falling edges move on to the next bit
                        if (sck_fall && (bit_cnt != 5'd0) && !frame_ok) begin
                            tx_sr  <= {tx_sr[14:0], 1'b0};
                            miso_q <= tx_sr[14];
                        end
                    end
                end
                ST_END: begin
                    miso_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Turn counter: a wrap across the 0/4095 boundary between valid samples
    // counts one revolution; the first sample only seeds the history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            turns      <= '0;
            prev_angle <= '0;
            prev_vld   <= 1'b0;
        end else if (angle_valid_i) begin
            prev_vld   <= 1'b1;
            prev_angle <= angle_i;
            if (prev_vld) begin
                if ((prev_angle > 12'd3071) && (angle_i < 12'd1024)) begin
                    turns <= turns + 12'd1;
                end else if ((prev_angle < 12'd1024) && (angle_i > 12'd3071)) begin
                    turns <= turns - 12'd1;
                end
            end
        end
    end

    assign miso_o    = miso_q;
    assign miso_oe_o = (state == ST_SHIFT);

endmodule

// File: tb/tb_a1339_spi_responder.sv
`timescale 1ns/1ps
// Bench for a1339_spi_responder: drives mode-3 SPI frames and checks responses through a queue.
// Latency: each frame's expected answer is queued when its command is sent and popped one frame later.
// Backpressure: none; SPI half-period is 8 system clocks.
module tb_a1339_spi_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck_i = 1'b1;
    logic        ss_n_i = 1'b1;
    logic        mosi_i = 1'b0;
    logic        miso_o;
    logic        miso_oe_o;
    logic [11:0] angle_i = 12'h000;
    logic        angle_valid_i = 1'b0;
    logic        error_i = 1'b0;
    logic [15:0] rx_word_o;
    logic        frame_done_o;
    logic        frame_error_o;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    logic [15:0] last_cmd = 16'h0000;
    logic [15:0] exp_q[$];

    a1339_spi_responder #(.ID_WORD(16'hA133), .SYNC_STAGES(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sck_i        (sck_i),
        .ss_n_i       (ss_n_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .miso_oe_o    (miso_oe_o),
        .angle_i      (angle_i),
        .angle_valid_i(angle_valid_i),
        .error_i      (error_i),
        .rx_word_o    (rx_word_o),
        .frame_done_o (frame_done_o),
        .frame_error_o(frame_error_o)
    );

    always #5 clock = ~clock;

    // Count the one-cycle status pulses
    always @(posedge clock) begin
        if (frame_done_o === 1'b1) done_cnt++;
        if (frame_error_o === 1'b1) ferr_cnt++;
    end

    task automatic half_period();
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic sck_bit(input logic b, output logic s);
        sck_i  = 1'b0;
        mosi_i = b;
        half_period();
        sck_i = 1'b1;
        s = miso_o;
        half_period();
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rxd);
        logic s;
        logic b;
        rxd = 16'h0000;
        ss_n_i = 1'b0;
        half_period();
        n_cmp++;
        if (miso_oe_o !== 1'b1) begin
            n_bad++;
            $display("FAIL oe_in_frame: got %b want 1", miso_oe_o);
        end
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? cmd[15-i] : 1'b1;
            sck_bit(b, s);
            if (i < 16) rxd[15-i] = s;
        end
        ss_n_i = 1'b1;
        half_period();
        half_period();
    endtask

    task automatic angle_sample(input logic [11:0] a);
        angle_i = a;
        angle_valid_i = 1'b1;
        @(posedge clock);
        #1;
        angle_valid_i = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Full frame: compares this frame's MISO with the queued answer, then
    // queues the answer expected for this command in the next frame
    task automatic xfer(input logic [15:0] cmd, input int nbits, input logic [15:0] exp_next);
        logic [15:0] rxd;
        logic [15:0] exp;
        int d0;
        d0 = done_cnt;
        spi_frame(cmd, nbits, rxd);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: cmd %h has no queued answer", cmd);
        end else begin
            exp = exp_q.pop_front();
            if (rxd !== exp) begin
                n_bad++;
                $display("FAIL miso_word: cmd %h got %h want %h", cmd, rxd, exp);
            end
        end
        last_cmd = cmd;
        n_cmp++;
        if (rx_word_o !== cmd) begin
            n_bad++;
            $display("FAIL rx_word: got %h want %h", rx_word_o, cmd);
        end
        n_cmp++;
        if (done_cnt !== d0 + 1) begin
            n_bad++;
            $display("FAIL frame_done: got %0d pulses want 1", done_cnt - d0);
        end
        n_cmp++;
        if (miso_oe_o !== 1'b0) begin
            n_bad++;
            $display("FAIL oe_after_frame: got %b want 0", miso_oe_o);
        end
        exp_q.push_back(exp_next);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (miso_oe_o !== 1'b0 || miso_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pins: oe %b miso %b want oe 0 miso 1", miso_oe_o, miso_o);
        end
        n_cmp++;
        if (rx_word_o !== 16'h0000 || frame_done_o !== 1'b0 || frame_error_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outs: rx %h done %b err %b want 0000 0 0", rx_word_o, frame_done_o, frame_error_o);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        exp_q.delete();
        exp_q.push_back(16'h0000);
    endtask

    task automatic test_angle_read();
        angle_i = 12'h123;
        error_i = 1'b0;
        xfer(16'h2000, 16, 16'h1123);
        xfer(16'h2000, 16, 16'h1123);
        error_i = 1'b1;
        xfer(16'h2000, 16, 16'h8123);
        error_i = 1'b0;
        xfer(16'h2000, 16, 16'h1123);
    endtask

    task automatic test_offset();
        angle_i = 12'h123;
        xfer(16'h9E23, 16, 16'h0000);
        xfer(16'h9F01, 16, 16'h0000);
        xfer(16'h2000, 16, 16'h1000);
        xfer(16'h2000, 16, 16'h1000);
        xfer(16'h1E00, 16, 16'h0023);
        xfer(16'h1F00, 16, 16'h0001);
        angle_i = 12'h100;
        xfer(16'h2000, 16, 16'h1FDD);
        xfer(16'h9E00, 16, 16'h0000);
        xfer(16'h9F00, 16, 16'h0000);
    endtask

    task automatic test_turns();
        angle_sample(12'hF00);
        angle_sample(12'h010);
        xfer(16'h2C00, 16, 16'h0001);
        angle_sample(12'h010);
        angle_sample(12'hF00);
        xfer(16'h2C00, 16, 16'h0000);
        angle_sample(12'h500);
        angle_sample(12'h010);
        angle_sample(12'hF00);
        xfer(16'h2C00, 16, 16'h0FFF);
    endtask

    task automatic test_abort();
        logic [15:0] rxd;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = ferr_cnt;
        angle_i = 12'h123;
        error_i = 1'b0;
        spi_frame(16'h2000, 9, rxd);
        n_cmp++;
        if (ferr_cnt !== e0 + 1) begin
            n_bad++;
            $display("FAIL abort_err_pulse: got %0d want 1", ferr_cnt - e0);
        end
        n_cmp++;
        if (done_cnt !== d0) begin
            n_bad++;
            $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0);
        end
        n_cmp++;
        if (rx_word_o !== last_cmd) begin
            n_bad++;
            $display("FAIL abort_rx_word: got %h want %h", rx_word_o, last_cmd);
        end
        xfer(16'h2000, 16, 16'h4123);
        xfer(16'h2000, 16, 16'h1123);
    endtask

    task automatic test_id_and_long_frame();
        xfer(16'h0000, 16, 16'hA133);
        xfer(16'h1234, 17, 16'h0000);
        xfer(16'h0000, 16, 16'hA133);
    endtask

    task automatic test_reset_midframe();
        logic [15:0] word;
        logic s;
        int d0;
        int e0;
        word = 16'h2000;
        ss_n_i = 1'b0;
        half_period();
        for (int i = 0; i < 7; i++) sck_bit(word[15-i], s);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (miso_oe_o !== 1'b0 || miso_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_reset_pins: oe %b miso %b want oe 0 miso 1", miso_oe_o, miso_o);
        end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        e0 = ferr_cnt;
        for (int i = 7; i < 16; i++) sck_bit(word[15-i], s);
        ss_n_i = 1'b1;
        half_period();
        half_period();
        n_cmp++;
        if (done_cnt !== d0 || ferr_cnt !== e0) begin
            n_bad++;
            $display("FAIL midframe_tail: done %0d err %0d pulses want 0 0", done_cnt - d0, ferr_cnt - e0);
        end
        last_cmd = 16'h0000;
        n_cmp++;
        if (rx_word_o !== last_cmd) begin
            n_bad++;
            $display("FAIL midframe_rx_word: got %h want 0000", rx_word_o);
        end
        exp_q.delete();
        exp_q.push_back(16'h0000);
        angle_i = 12'h123;
        error_i = 1'b0;
        xfer(16'h2000, 16, 16'h1123);
        xfer(16'h0000, 16, 16'hA133);
        xfer(16'h2C00, 16, 16'h0000);
        xfer(16'h0000, 16, 16'hA133);
    endtask

    initial begin
        test_reset();
        test_angle_read();
        test_offset();
        test_turns();
        test_abort();
        test_id_and_long_frame();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/a1339_spi_responder.md
Name: a1339_spi_responder

Overview:
SPI slave that emulates one A1339 angle sensor and answers the platform's SPI angle-sensor master. It is used for hardware-in-the-loop and bench verification of the MSJ platform control path without physical sensors.
- Angle, error and turn data come from a model or testbench input.
- Responses are full-duplex and pipelined: the answer to a command is shifted out in the following frame.

Parameters:
ID_WORD, 16'hA133, constant returned for register address 0x00
SYNC_STAGES, 2, synchroniser depth on sck_i, ss_n_i and mosi_i

Ports:
clock  in  1  system clock; sck_i must not exceed clock/8
reset_n  in  1  asynchronous, active-low reset
sck_i  in  1  SPI clock, mode 3 (CPOL=1, CPHA=1), idles high
ss_n_i  in  1  slave select, active low
mosi_i  in  1  master-out data, MSB first
miso_o  out  1  slave-out data, MSB first
miso_oe_o  out  1  MISO output enable; high only while ss_n is low (synchronised)
angle_i  in  12  raw angle from the model
angle_valid_i  in  1  strobe; angle_i is sampled for turn counting
error_i  in  1  sensor error flag from the model
rx_word_o  out  16  last complete command received
frame_done_o  out  1  one-cycle pulse when a 16-bit frame completes
frame_error_o  out  1  one-cycle pulse when a frame aborts with a bit count other than 16

Behaviour:
- Reset values:
  - miso_o=1, miso_oe_o=0, rx_word_o=0, both pulses 0.
  - offset=0, turns=0, frame-error sticky flag=0.
  - Pending response word=16'h0000.
  - FSM in IDLE.
- Input handling:
  - All SPI inputs pass through SYNC_STAGES flip-flops.
  - sck rising and falling edges are detected from the synchronised signal.
- FSM, IDLE -> SHIFT:
  - Triggered by the ss_n falling edge.
  - Pending response is loaded into the TX shift register.
  - miso_o = response bit 15; bit counter = 0.
- FSM, SHIFT:
  - sck rising: shift mosi into the RX register; bit counter +1.
  - sck falling: advance the TX register to the next bit.
  - After 16 rising edges, further edges are ignored until ss_n rises.
- FSM, SHIFT -> END, on ss_n rising edge:
  - If count==16: rx_word_o updated, frame_done_o pulses, the command executes, and the new pending response is latched from current values.
  - Otherwise: frame_error_o pulses, the sticky flag is set, the command is discarded and the pending response is unchanged.
  - END -> IDLE next cycle.
- Command format: [15]=write, [14:8]=7-bit address, [7:0]=write data.
- Writes:
  - 0x1E: offset[7:0] <= data.
  - 0x1F: offset[11:8] <= data[3:0].
  - Writes to other addresses are ignored.
  - The pending response after a write is 16'h0000.
- Read responses:
  - 0x00: ID_WORD.
  - 0x1E: {8'h00, offset[7:0]}.
  - 0x1F: {12'h000, offset[11:8]}.
  - 0x20 (angle frame): [15]=error_i, [14]=sticky flag, [13]=0, [12]=odd parity (total ones in the 16 bits is odd), [11:0]=(angle_i - offset) mod 4096. A read of 0x20 clears the sticky flag when the response is latched.
  - 0x2C: {4'h0, turns[11:0]}.
  - All other addresses: 16'h0000.
- Turn counter, evaluated on angle_valid_i against the previous valid sample:
  - prev>3071 and new<1024: turns+1.
  - prev<1024 and new>3071: turns-1.
  - 12-bit wrap-around arithmetic.
  - The first valid sample after reset only initialises prev.
- Simultaneous events: angle_valid_i in the same cycle as the response latch means the latch uses pre-update turns. The angle field uses angle_i as present that cycle.
- Reset mid-frame: the frame is abandoned, all state returns to reset values, and the remainder of the frame is ignored until the next ss_n falling edge.

Test Plan:
- Reset -> miso_oe_o=0, miso_o=1. First frame (mosi 0x2000) returns 0x0000. Second frame with angle_i=0x123, error_i=0 returns 0x1123.
- Write frames 0x9E23 then 0x9F01 -> offset=0x123. Read 0x2000 twice:
  - angle_i=0x123 -> second frame returns 0x1000.
  - angle_i=0x100 -> returns 0x1FDD.
- angle_valid_i with 0xF00 then 0x010 -> read 0x2C00 returns 0x0001. Then 0x010 then 0xF00 -> returns 0x0000.
- Abort after 9 sck edges -> frame_error_o pulse, rx_word_o unchanged. Then with angle_i=0x123, offset 0:
  - the next angle read returns 0x4123;
  - the following angle read returns 0x1123.
- Read 0x0000 -> next frame returns 0xA133. A 17th sck edge within a frame is ignored and rx_word_o equals the first 16 bits.
- Assert reset_n low at bit 7 -> miso_oe_o=0 immediately. The next full read of 0x20 returns 0x0000 (pending cleared).
